// File: rtl/fft_pkg.sv
// Shared constants and index helpers for the FFT output reorder buffer.
package fft_pkg;

    localparam int DEF_N     = 128;
    localparam int DEF_WIDTH = 16;
    localparam int MAX_NN    = 12;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i <= MAX_NN + 1; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Reverses the low nn bits of x; bits at and above nn come back as zero.
    function automatic logic [MAX_NN-1:0] bitrev(input logic [MAX_NN-1:0] x, input int nn);
        logic [MAX_NN-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_NN; i++) begin
            if (i < nn) r[i] = x[nn-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame RAM holding both ping-pong banks; the address MSB picks the bank.
module fft_reorder_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_q
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Streaming bit-reversed to natural-order reorder buffer with ping-pong banks,
// placed directly after the SDF FFT core.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    localparam int NN   = log2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    input  logic             bitrev_en,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic [NN-1:0]    odata_idx,
    output logic             odata_sop,
    output logic             odata_eop
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_RD   = 1'b1;
    localparam logic [NN-1:0] LAST    = NN'(N - 1);

    logic [NN-1:0]      wcnt_q, wcnt_d;
    logic               wbank_q, wbank_d;
    logic [1:0]         full_q, full_d;
    logic [1:0]         mode_q, mode_d;
    logic [0:0]         state_q, state_d;
    logic               rbank_q, rbank_d;
    logic [NN-1:0]      rcnt_q, rcnt_d;
    logic               rvld_q, rvld_d;
    logic [NN-1:0]      ridx_q, ridx_d;
    logic               oen_q, oen_d;
    logic [WIDTH-1:0]   or_q, or_d;
    logic [WIDTH-1:0]   oi_q, oi_d;
    logic [NN-1:0]      oidx_q, oidx_d;
    logic               osop_q, osop_d;
    logic               oeop_q, oeop_d;

    logic               wr_mode;
    logic [NN-1:0]      wk_rev;
    logic [NN:0]        waddr;
    logic [NN:0]        raddr;
    logic               rd_issue;
    logic [1:0]         full_set;
    logic [1:0]         full_clr;
    logic [2*WIDTH-1:0] rdata;

    fft_reorder_ram #(
        .AW (NN + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clk     (clock),
        .we      (idata_en),
        .waddr   (waddr),
        .wdata   ({idata_r, idata_i}),
        .re      (rd_issue),
        .raddr   (raddr),
        .rdata_q (rdata)
    );

    always_comb begin
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        mode_d   = mode_q;
        full_set = '0;
        full_clr = '0;
        state_d  = state_q;
        rbank_d  = rbank_q;
        rcnt_d   = rcnt_q;

        // The frame's mode is latched with sample 0, so that sample uses the live input.
        wk_rev  = NN'(bitrev(MAX_NN'(wcnt_q), NN));
        wr_mode = (wcnt_q == '0) ? bitrev_en : mode_q[wbank_q];
        waddr   = {wbank_q, (wr_mode ? wk_rev : wcnt_q)};

        if (idata_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) mode_d[wbank_q] = bitrev_en;
            if (wcnt_q == LAST) begin
                full_set[wbank_q] = 1'b1;
                wbank_d           = ~wbank_q;
            end
        end

        // An idle reader issues address 0 in the same cycle it sees its bank full.
        rd_issue = (state_q == ST_RD) || full_q[rbank_q];
        raddr    = {rbank_q, rcnt_q};
        if (rd_issue) begin
            rcnt_d  = rcnt_q + 1'b1;
            state_d = ST_RD;
            if (rcnt_q == LAST) begin
                full_clr[rbank_q] = 1'b1;
                rbank_d           = ~rbank_q;
                state_d = (full_q[~rbank_q] || full_set[~rbank_q]) ? ST_RD : ST_IDLE;
            end
        end
        full_d = (full_q & ~full_clr) | full_set;

        rvld_d = rd_issue;
        ridx_d = rcnt_q;

        oen_d  = rvld_q;
        or_d   = rvld_q ? rdata[2*WIDTH-1:WIDTH] : '0;
        oi_d   = rvld_q ? rdata[WIDTH-1:0] : '0;
        oidx_d = rvld_q ? ridx_q : '0;
        osop_d = rvld_q && (ridx_q == '0);
        oeop_d = rvld_q && (ridx_q == LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
            full_q  <= '0;
            mode_q  <= '0;
            state_q <= ST_IDLE;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
            rvld_q  <= 1'b0;
            ridx_q  <= '0;
            oen_q   <= 1'b0;
            or_q    <= '0;
            oi_q    <= '0;
            oidx_q  <= '0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
            full_q  <= full_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
            rvld_q  <= rvld_d;
            ridx_q  <= ridx_d;
            oen_q   <= oen_d;
            or_q    <= or_d;
            oi_q    <= oi_d;
            oidx_q  <= oidx_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
        end
    end

    assign odata_en  = oen_q;
    assign odata_r   = or_q;
    assign odata_i   = oi_q;
    assign odata_idx = oidx_q;
    assign odata_sop = osop_q;
    assign odata_eop = oeop_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: an N=8 vector table plus N=128 frame sequences.
module tb_fft_out_reorder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errs   = 0;

    // N=128 instance
    logic        a_en, a_brev, a_oen, a_sop, a_eop;
    logic [15:0] a_r, a_i, a_or, a_oi;
    logic [6:0]  a_oidx;
    // N=8 instance
    logic        b_en, b_brev, b_oen, b_sop, b_eop;
    logic [15:0] b_r, b_i, b_or, b_oi;
    logic [2:0]  b_oidx;

    fft_out_reorder #(.N(128), .WIDTH(16)) dut (
        .clock(clk), .reset(rst_n), .idata_en(a_en), .idata_r(a_r), .idata_i(a_i),
        .bitrev_en(a_brev), .odata_en(a_oen), .odata_r(a_or), .odata_i(a_oi),
        .odata_idx(a_oidx), .odata_sop(a_sop), .odata_eop(a_eop));

    fft_out_reorder #(.N(8), .WIDTH(16)) dut8 (
        .clock(clk), .reset(rst_n), .idata_en(b_en), .idata_r(b_r), .idata_i(b_i),
        .bitrev_en(b_brev), .odata_en(b_oen), .odata_r(b_or), .odata_i(b_oi),
        .odata_idx(b_oidx), .odata_sop(b_sop), .odata_eop(b_eop));

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic [6:0]  idx;
        logic        sop;
        logic        eop;
        int          cyc;
    } out_t;

    typedef struct {
        logic        en;
        logic [15:0] r;
        logic [15:0] i;
        logic        brev;
        logic        x_en;
        logic [15:0] x_r;
        logic [15:0] x_i;
        logic [2:0]  x_idx;
        logic        x_sop;
        logic        x_eop;
    } vec_t;

    out_t mon_q[$];
    out_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] rev7(input logic [6:0] x);
        logic [6:0] r;
        for (int b = 0; b < 7; b++) r[b] = x[6-b];
        return r;
    endfunction

    // Output monitor for the N=128 instance: collect valid samples, idle cycles must be all zero.
    always @(negedge clk) begin
        out_t o;
        if (a_oen === 1'b1) begin
            o.r = a_or; o.i = a_oi; o.idx = a_oidx; o.sop = a_sop; o.eop = a_eop; o.cyc = cyc;
            mon_q.push_back(o);
        end else begin
            chk("idle outputs zero", {a_oen, a_or, a_oi, a_oidx, a_sop, a_eop}, 64'h0);
        end
    end

    // Bin b of a frame carries b*mul+off; bit-reversed frames present bin rev7(k) as sample k.
    task automatic drive_frame(input bit rev, input bit toggle, input bit gaps,
                               input int mul, input int off, output int lw);
        out_t        e;
        logic [15:0] v;
        int          bin;
        for (int k = 0; k < 128; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                a_en = 1'b0; a_r = 16'($urandom); a_i = 16'($urandom);
                a_brev = 1'($urandom);
            end
            @(negedge clk);
            bin    = rev ? int'(rev7(7'(k))) : k;
            v      = 16'(bin * mul + off);
            a_en   = 1'b1;
            a_r    = v;
            a_i    = ~v;
            a_brev = (k == 0 || !toggle) ? rev : 1'($urandom_range(0, 1));
            lw     = cyc + 1;
        end
        for (int n = 0; n < 128; n++) begin
            e.r   = 16'(n * mul + off);
            e.i   = ~e.r;
            e.idx = 7'(n);
            e.sop = (n == 0);
            e.eop = (n == 127);
            e.cyc = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int b;
        b = 0;
        @(negedge clk);
        a_en = 1'b0;
        while (mon_q.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        repeat (4) @(negedge clk);
        chk({tag, " output count"}, mon_q.size(), n);
    endtask

    task automatic compare_out(input string tag, input int lw);
        int m;
        m = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        if (m > 0) chk({tag, " first-output latency"}, mon_q[0].cyc, lw + 2);
        for (int j = 0; j < m; j++) begin
            chk($sformatf("%s[%0d] real", tag, j), mon_q[j].r, exp_q[j].r);
            chk($sformatf("%s[%0d] imag", tag, j), mon_q[j].i, exp_q[j].i);
            chk($sformatf("%s[%0d] idx", tag, j), mon_q[j].idx, exp_q[j].idx);
            chk($sformatf("%s[%0d] sop", tag, j), mon_q[j].sop, exp_q[j].sop);
            chk($sformatf("%s[%0d] eop", tag, j), mon_q[j].eop, exp_q[j].eop);
            chk($sformatf("%s[%0d] contiguous", tag, j), mon_q[j].cyc, mon_q[0].cyc + j);
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[19];
        int   lw, lw2, b;
        bit   hit;

        // N=8: samples arrive as bins 0,4,2,6,1,5,3,7; bin 0 shows on row 10, bin 7 (eop) on row 17
        tbl[0]  = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0004, 16'hFFFB, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0002, 16'hFFFD, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0006, 16'hFFF9, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0005, 16'hFFFA, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0003, 16'hFFFC, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0007, 16'hFFF8, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 3'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'hFFFE, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'hFFFD, 3'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'hFFFC, 3'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'hFFFB, 3'd4, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0005, 16'hFFFA, 3'd5, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0006, 16'hFFF9, 3'd6, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'hFFF8, 3'd7, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        a_en = 1'b0; a_r = '0; a_i = '0; a_brev = 1'b0;
        b_en = 1'b0; b_r = '0; b_i = '0; b_brev = 1'b0;

        // Reset held with random inputs: all outputs stay zero
        repeat (5) begin
            @(negedge clk);
            chk("reset outputs N128", {a_oen, a_or, a_oi, a_oidx, a_sop, a_eop}, 64'h0);
            chk("reset outputs N8", {b_oen, b_or, b_oi, b_oidx, b_sop, b_eop}, 64'h0);
            a_en = 1'($urandom); a_r = 16'($urandom); a_i = 16'($urandom); a_brev = 1'($urandom);
            b_en = 1'($urandom); b_r = 16'($urandom); b_i = 16'($urandom); b_brev = 1'($urandom);
        end
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0;
        rst_n = 1'b1;

        // N=8 table
        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            chk($sformatf("n8 row%0d en", r), b_oen, tbl[r].x_en);
            chk($sformatf("n8 row%0d real", r), b_or, tbl[r].x_r);
            chk($sformatf("n8 row%0d imag", r), b_oi, tbl[r].x_i);
            chk($sformatf("n8 row%0d idx", r), b_oidx, tbl[r].x_idx);
            chk($sformatf("n8 row%0d sop", r), b_sop, tbl[r].x_sop);
            chk($sformatf("n8 row%0d eop", r), b_eop, tbl[r].x_eop);
            b_en = tbl[r].en; b_r = tbl[r].r; b_i = tbl[r].i; b_brev = tbl[r].brev;
        end

        // Single bit-reversed frame
        mon_q.delete(); exp_q.delete();
        drive_frame(1'b1, 1'b0, 1'b0, 1, 0, lw);
        wait_out("s2", 128, 300);
        compare_out("s2", lw);

        // Three back-to-back frames
        drive_frame(1'b1, 1'b0, 1'b0, 1, 0, lw);
        drive_frame(1'b1, 1'b0, 1'b0, 3, 200, lw2);
        drive_frame(1'b1, 1'b0, 1'b0, 5, 1000, lw2);
        wait_out("s3", 384, 600);
        compare_out("s3", lw);

        // Random input gaps
        drive_frame(1'b1, 1'b0, 1'b1, 1, 0, lw);
        wait_out("s4", 128, 300);
        compare_out("s4", lw);

        // Pass-through frame then reordered frame, bitrev_en toggling mid-frame
        drive_frame(1'b0, 1'b1, 1'b0, 7, 300, lw);
        drive_frame(1'b1, 1'b1, 1'b0, 2, 5000, lw2);
        wait_out("s5", 256, 500);
        compare_out("s5", lw);

        // Reset while bin 60 is on the output, then a fresh frame
        drive_frame(1'b1, 1'b0, 1'b0, 1, 0, lw);
        @(negedge clk);
        a_en = 1'b0;
        hit = 1'b0;
        b = 0;
        while (!hit && b < 400) begin
            @(negedge clk);
            b++;
            if (a_oen === 1'b1 && a_oidx === 7'd60) hit = 1'b1;
        end
        chk("s6 reached bin 60", hit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("s6 odata_en on reset", a_oen, 1'b0);
        chk("s6 outputs on reset", {a_or, a_oi, a_oidx, a_sop, a_eop}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_q.delete(); exp_q.delete();
        drive_frame(1'b1, 1'b0, 1'b0, 3, 7, lw);
        wait_out("s6", 128, 300);
        compare_out("s6", lw);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
